// File: rtl/pingpong_disp_pkg.sv
// Shared types and constants for the ping-pong counter display path.
package pingpong_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // Active-high seven-segment patterns, bit 0 = segment a, bit 6 = segment g.
  localparam logic [9:0][7:0] SegPatterns = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };
  localparam logic [7:0] SegBlank = 8'h00;

  // Decode one BCD digit; the codes 10..15 never occur and show nothing.
  function automatic logic [7:0] seg_decode(logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SegPatterns[0];
      4'd1:    s = SegPatterns[1];
      4'd2:    s = SegPatterns[2];
      4'd3:    s = SegPatterns[3];
      4'd4:    s = SegPatterns[4];
      4'd5:    s = SegPatterns[5];
      4'd6:    s = SegPatterns[6];
      4'd7:    s = SegPatterns[7];
      4'd8:    s = SegPatterns[8];
      4'd9:    s = SegPatterns[9];
      default: s = SegBlank;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pingpong_bin2bcd.sv
// Iterative double-dabble converter: one input bit per clock, plus flag snapshots.
module pingpong_bin2bcd
  import pingpong_disp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_val,
  input  logic                  in_dir,
  input  logic                  in_max,
  input  logic                  in_min,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  dir_snap,
  output logic                  max_led,
  output logic                  min_led
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  last_val_q, last_val_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              force_q, force_d;
  logic              dir_cap_q, dir_cap_d, max_cap_q, max_cap_d, min_cap_q, min_cap_d;
  logic              done_q, done_d, dir_q, dir_d, max_led_q, max_led_d, min_led_q, min_led_d;

  // State register; reset discards any conversion in flight and forces a fresh one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      last_val_q <= '0;
      work_q     <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      force_q    <= 1'b1;
      dir_cap_q  <= 1'b0;
      max_cap_q  <= 1'b0;
      min_cap_q  <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      max_led_q  <= 1'b0;
      min_led_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      last_val_q <= last_val_d;
      work_q     <= work_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      force_q    <= force_d;
      dir_cap_q  <= dir_cap_d;
      max_cap_q  <= max_cap_d;
      min_cap_q  <= min_cap_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
      max_led_q  <= max_led_d;
      min_led_q  <= min_led_d;
    end
  end

  // Next-state: capture on change (or forced), shift-add-3 per bit, publish on DONE.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    last_val_d = last_val_q;
    work_d     = work_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    force_d    = force_q;
    dir_cap_d  = dir_cap_q;
    max_cap_d  = max_cap_q;
    min_cap_d  = min_cap_q;
    done_d     = 1'b0;
    dir_d      = dir_q;
    max_led_d  = max_led_q;
    min_led_d  = min_led_q;

    // A digit is at most 9 before correction, so +3 never carries out of the nibble.
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end

    unique case (state_q)
      StIdle: begin
        if (force_q || (in_val != last_val_q)) begin
          shift_d    = in_val;
          last_val_d = in_val;
          dir_cap_d  = in_dir;
          max_cap_d  = in_max;
          min_cap_d  = in_min;
          work_d     = '0;
          cnt_d      = '0;
          force_d    = 1'b0;
          state_d    = StConv;
        end
      end
      StConv: begin
        {work_d, shift_d} = {adj, shift_q} << 1;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        bcd_d     = work_q;
        done_d    = 1'b1;
        dir_d     = dir_cap_q;
        max_led_d = max_cap_q;
        min_led_d = min_cap_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bcd      = bcd_q;
  assign busy     = (state_q == StConv);
  assign done     = done_q;
  assign dir_snap = dir_q;
  assign max_led  = max_led_q;
  assign min_led  = min_led_q;

endmodule

// File: rtl/pingpong_disp.sv
// Ping-pong counter display: BCD conversion plus multiplexed seven-segment scan.
module pingpong_disp
  import pingpong_disp_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_val,
  input  logic                in_dir,
  input  logic                in_max,
  input  logic                in_min,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [DIGITS-1:0]   an,
  output logic [7:0]          seg,
  output logic                max_led,
  output logic                min_led
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              dir_snap;
  logic [DivW-1:0]   div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        digit;
  logic              blank;

  pingpong_bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_dir   (in_dir),
    .in_max   (in_max),
    .in_min   (in_min),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .dir_snap (dir_snap),
    .max_led  (max_led),
    .min_led  (min_led)
  );

  // Scan registers; an and seg move together on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= DIGITS'(1);
      seg_q <= seg_decode(4'd0);
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  // Free-running digit scan, leading-zero blanking and segment decode for the next digit.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    an_d  = '0;
    digit = '0;
    blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = (idx_d == IdxW'(k));
      if (idx_d == IdxW'(k)) begin
        digit = bcd[4*k +: 4];
        // Blank when this digit and every digit above it are zero.
        blank = (k != 0) && ((bcd >> (4 * k)) == '0);
      end
    end

    seg_d    = blank ? SegBlank : seg_decode(digit);
    seg_d[7] = (idx_d == '0) && dir_snap;
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_pingpong_disp.sv
// Bench for pingpong_disp: arithmetic reference model checked every cycle plus directed literals.
module tb_pingpong_disp;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_val = '0;
  logic        in_dir = 1'b0, in_max = 1'b0, in_min = 1'b0;
  logic [11:0] bcd;
  logic        busy, done, max_led, min_led;
  logic [2:0]  an;
  logic [7:0]  seg;

  pingpong_disp #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_dir  (in_dir),
    .in_max  (in_max),
    .in_min  (in_min),
    .bcd     (bcd),
    .busy    (busy),
    .done    (done),
    .an      (an),
    .seg     (seg),
    .max_led (max_led),
    .min_led (min_led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] pats [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value held as an integer, conversion as a countdown.
  int   m_val = 0, m_cap = 0, m_last = 0, m_t = 0, m_div = 0, m_idx = 0;
  bit   m_force = 1, m_done = 0, m_dir = 0, m_max = 0, m_min = 0;
  bit   cap_dir = 0, cap_max = 0, cap_min = 0;
  logic [7:0] m_seg = 8'h3F;
  bit   chk_en = 0;

  function automatic logic [7:0] exp_seg(input int idx, input int v, input bit dir);
    int p;
    int d;
    logic [7:0] s;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    d = (v / p) % 10;
    s = (idx > 0 && v < p) ? 8'h00 : pats[d];
    s[7] = (idx == 0) && dir;
    return s;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_val = 0; m_last = 0; m_t = 0; m_force = 1; m_done = 0;
      m_dir = 0; m_max = 0; m_min = 0;
      m_div = 0; m_idx = 0; m_seg = 8'h3F;
    end else begin
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_div++;
      end
      m_seg  = exp_seg(m_idx, m_val, m_dir);
      m_done = 0;
      if (m_t > 0) begin
        m_t--;
        if (m_t == 0) begin
          m_val = m_cap; m_dir = cap_dir; m_max = cap_max; m_min = cap_min; m_done = 1;
        end
      end else if (m_force || in_val != m_last[7:0]) begin
        m_cap = in_val; m_last = in_val;
        cap_dir = in_dir; cap_max = in_max; cap_min = in_min;
        m_t = WIDTH + 1;
        m_force = 0;
      end
    end
    chk_en = 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bcd", bcd, to_bcd(m_val));
      chk("busy", busy, m_t >= 2);
      chk("done", done, m_done);
      chk("an", an, 32'(1) << m_idx);
      chk("seg", seg, m_seg);
      chk("max_led", max_led, m_max);
      chk("min_led", min_led, m_min);
    end
  end

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < limit);
    chk("done_seen", done, 1);
  endtask

  task automatic wait_busy(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < limit);
    chk("busy_seen", busy, 1);
  endtask

  task automatic scan_check(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (an == 3'b001)      chk("scan_d0", seg, e0);
      else if (an == 3'b010) chk("scan_d1", seg, e1);
      else                   chk("scan_d2", seg, {5'b0, an} == 8'h04 ? e2 : 8'hxx);
    end
  endtask

  initial begin
    int n;
    int cnt;
    logic [2:0] prev;
    int e;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_an", an, 3'b001);
    chk("rst_seg", seg, 8'h3F);

    // Forced first conversion of zero.
    rst = 1'b0;
    wait_done(40, n);
    chk("lat_first", n, 10);
    chk("bcd_zero", bcd, 12'h000);

    // Full-scale value with max flag.
    in_val = 8'd255; in_max = 1'b1;
    wait_done(40, n);
    chk("lat_255", n, 10);
    chk("bcd_255", bcd, 12'h255);
    chk("max_led_255", max_led, 1);
    repeat (2) @(negedge clk);
    scan_check(8'h6D, 8'h6D, 8'h5B);

    // Small value counting up: decimal point lit, upper digits blanked.
    in_val = 8'd7; in_dir = 1'b1; in_max = 1'b0;
    wait_done(40, n);
    chk("bcd_7", bcd, 12'h007);
    chk("max_led_7", max_led, 0);
    repeat (2) @(negedge clk);
    scan_check(8'h87, 8'h00, 8'h00);

    // Change during conversion is picked up afterwards.
    in_val = 8'd12; in_dir = 1'b0; in_min = 1'b1;
    wait_busy(20);
    repeat (2) @(negedge clk);
    in_val = 8'd34;
    wait_done(40, n);
    chk("bcd_12", bcd, 12'h012);
    chk("min_led_12", min_led, 1);
    wait_done(40, n);
    chk("lat_34", n, 10);
    chk("bcd_34", bcd, 12'h034);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("no_third_done", cnt, 0);

    // Reset in the middle of a conversion.
    in_val = 8'd99; in_min = 1'b0;
    wait_busy(20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bcd", bcd, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_an", an, 3'b001);
    chk("mid_rst_seg", seg, 8'h3F);
    wait_done(40, n);
    chk("lat_99", n, 10);
    chk("bcd_99", bcd, 12'h099);

    // Scan cadence: four cycles per digit, wrapping back to digit 0.
    n = 0;
    prev = an;
    do begin
      @(negedge clk);
      n++;
      e = (prev == 3'b100 && an == 3'b001) ? 1 : 0;
      prev = an;
    end while (e == 0 && n < 20);
    chk("scan_sync", an, 3'b001);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("scan_an", an, (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : (i < 12) ? 3'b100 : 3'b001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
